adjust_step_gen: RTL and testbench
==================================

# adjust_step_gen

Initiator-side step generator for the time/alarm adjust counters. It debounces the raw up and down push-buttons and emits single-cycle `up`/`Down` step pulses, with press-and-hold auto-repeat. The pulses are wired directly to the `up`/`Down` inputs of the adjust counters, which step once per clock while their input is high, so every step must be exactly one clock wide.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable clocks required before a debounced level changes; must be ≥1.
- `HOLD_CYCLES`, default 25000000: clocks from the first pulse to the first auto-repeat pulse; must be ≥2.
- `RATE_CYCLES`, default 5000000: clocks between auto-repeat pulses; must be ≥2.
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  adjust mode enable; when low, no pulses are emitted.
- `btn_up`  in  1  raw, asynchronous up button, active-high.
- `btn_down`  in  1  raw, asynchronous down button, active-high.
- `up`  out  1  registered one-cycle increment pulse.
- `Down`  out  1  registered one-cycle decrement pulse.

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer. The debounced level `db` takes the new synchronized value only after that value has differed from `db` for `DB_CYCLES` consecutive clocks. Any bounce back restarts the count.
- The FSM runs on `db_up`/`db_dn` and has four states:
  - **IDLE**: if exactly one of `db_up`/`db_dn` is high and `en`=1, latch the direction, pulse once, and go to HOLD. If both are high, go to LOCK.
  - **HOLD**: count `HOLD_CYCLES`. On expiry, pulse and go to REPEAT.
  - **REPEAT**: pulse every `RATE_CYCLES`.
  - **LOCK**: no pulses. Return to IDLE only when both debounced levels are low.
- In HOLD and REPEAT:
  - Release of the latched button returns the FSM to IDLE and emits no pulse that cycle.
  - The other button rising goes to LOCK.
- A press already held when `en` rises does not generate pulses. The FSM stays in IDLE until both buttons release.
- `en` low:
  - forces IDLE;
  - forces `up`=`Down`=0 on the next edge;
  - clears the interval counter.
- Debouncers run regardless of `en`.
- `up` and `Down` are never high in the same cycle.
- Interval counter:
  - width is $clog2 of max(`HOLD_CYCLES`, `RATE_CYCLES`);
  - reloads to 0 on every state entry and on every pulse;
  - never wraps mid-interval.
- Debounce counter width is $clog2(`DB_CYCLES`+1).

## Timing
- Reset values: `up`=0, `Down`=0, state=IDLE, synchronizers=0, `db`=0, all counters=0. Reset mid-hold or mid-pulse clears everything at that edge. A button still held after reset follows the `en`-rise rule: no pulses until release.
- Raw edge to `db` change: `DB_CYCLES`+2 clocks.
- `db` rise to first pulse: 1 clock, registered. Total raw-to-first-pulse latency is `DB_CYCLES`+3 clocks.
- First pulse to second pulse: `HOLD_CYCLES` clocks.
- Subsequent pulses are spaced `RATE_CYCLES` clocks apart.
- Every pulse is exactly one clock wide.
- Release: after `db` falls, no further pulse is emitted. A pulse already scheduled for the same cycle is suppressed.
- Press and release in the same debounce window: no `db` change and no pulse.

## Structure
- Package `adjust_step_pkg`: FSM state enum {IDLE, HOLD, REPEAT, LOCK}, direction type {DIR_UP, DIR_DN}, and default parameter constants.
- Sub-module `btn_debounce`, parameter `DB_CYCLES`, contains the synchronizer and debouncer. It is instantiated twice, once per button.
- The top level contains the FSM, the interval counter and the output registers.

## Test plan
All scenarios use `DB_CYCLES`=4, `HOLD_CYCLES`=10, `RATE_CYCLES`=3.

- **Single press**: `en`=1, `btn_up` high for 8 clocks then low.
  - Exactly one `up` pulse, 7 clocks after the rise.
  - No `Down` pulse.
- **Bounce rejection**: `btn_down` toggles every 2 clocks for 20 clocks, then settles low.
  - No pulses and `db_dn` stays 0.
- **Auto-repeat**: hold `btn_up` for 40 clocks.
  - `up` pulses at T, T+10, T+13, T+16, and so on, with T = rise+7.
  - After release, no pulse once `db` falls.
- **Simultaneous press**: `btn_down` held in REPEAT, then `btn_up` also pressed.
  - `Down` pulses stop and there are no `up` pulses.
  - Releasing only `btn_down` gives no pulses.
  - Releasing both, then pressing `btn_up`, gives a fresh first pulse.
- **Enable gating**: `btn_up` held, `en` driven 0 mid-REPEAT, then back to 1 while still held.
  - Pulses stop on the next edge and nothing is emitted until release.
  - A re-press after release pulses normally.
- **Reset mid-operation**: `reset` for 1 clock in HOLD with `btn_down` still held.
  - `up`=`Down`=0 and state=IDLE at the next edge.
  - No pulses until `btn_down` releases and is pressed again.

Source files
------------

// File: rtl/adjust_step_pkg.sv
// Shared types and default timing constants for the adjust step generator.
// FSM state encoding, latched direction, and clock-count defaults.
package adjust_step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_t;

    localparam int DEF_DB_CYCLES   = 500000;
    localparam int DEF_HOLD_CYCLES = 25000000;
    localparam int DEF_RATE_CYCLES = 5000000;

endpackage

// File: rtl/adjust_step_gen_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a restart-on-bounce debouncer.
// A raw edge reaches db after DB_CYCLES+2 clocks; quiet flags a settled, released button.
module btn_debounce
    import adjust_step_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic quiet
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            // Any clock where the synced level agrees with db restarts the window.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign quiet = !s2 && !db;

endmodule

// File: rtl/adjust_step_gen.sv
// Debounced up/down buttons to one-clock step pulses with press-and-hold auto-repeat.
// First pulse DB_CYCLES+3 clocks after the raw press, then HOLD_CYCLES, then every RATE_CYCLES.
module adjust_step_gen
    import adjust_step_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int RATE_CYCLES = DEF_RATE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic btn_up,
    input  logic btn_down,
    output logic up,
    output logic Down
);

    localparam int MAX_INTERVAL = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
    localparam int IW = $clog2(MAX_INTERVAL);
    localparam logic [IW-1:0] HOLD_LAST = IW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] RATE_LAST = IW'(RATE_CYCLES - 1);

    logic db_up;
    logic db_dn;
    logic quiet_up;
    logic quiet_dn;

    state_t        state;
    state_t        state_nxt;
    dir_t          dir;
    dir_t          dir_nxt;
    logic [IW-1:0] icnt;
    logic [IW-1:0] icnt_nxt;
    logic          pulse_nxt;
    logic          held;
    logic          other;
    logic          armed;
    logic          armed_nxt;
    logic [1:0]    settle;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_up),
        .db    (db_up),
        .quiet (quiet_up)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_down),
        .db    (db_dn),
        .quiet (quiet_dn)
    );

    // A press may only start from IDLE once both buttons were seen released with
    // en high; the settle delay covers the synchronizer refilling after reset.
    always_comb begin
        armed_nxt = armed;
        if (settle == 2'd2 && quiet_up && quiet_dn) begin
            armed_nxt = 1'b1;
        end else if (!en) begin
            armed_nxt = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        pulse_nxt = 1'b0;
        icnt_nxt  = icnt + 1'b1;
        held      = (dir == DIR_UP) ? db_up : db_dn;
        other     = (dir == DIR_UP) ? db_dn : db_up;
        if (!en) begin
            state_nxt = IDLE;
            icnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    icnt_nxt = '0;
                    if (db_up && db_dn) begin
                        state_nxt = LOCK;
                    end else if (armed && (db_up ^ db_dn)) begin
                        dir_nxt   = db_up ? DIR_UP : DIR_DN;
                        pulse_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    // Release and conflict take priority over a pulse due this cycle.
                    if (other) begin
                        state_nxt = LOCK;
                        icnt_nxt  = '0;
                    end else if (!held) begin
                        state_nxt = IDLE;
                        icnt_nxt  = '0;
                    end else if (icnt == ((state == HOLD) ? HOLD_LAST : RATE_LAST)) begin
                        pulse_nxt = 1'b1;
                        state_nxt = REPEAT;
                        icnt_nxt  = '0;
                    end
                end
                LOCK: begin
                    icnt_nxt = '0;
                    if (!db_up && !db_dn) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    icnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            dir    <= DIR_UP;
            icnt   <= '0;
            armed  <= 1'b0;
            settle <= 2'd0;
            up     <= 1'b0;
            Down   <= 1'b0;
        end else begin
            state  <= state_nxt;
            dir    <= dir_nxt;
            icnt   <= icnt_nxt;
            armed  <= armed_nxt;
            settle <= (settle == 2'd2) ? settle : settle + 2'd1;
            up     <= pulse_nxt && (dir_nxt == DIR_UP);
            Down   <= pulse_nxt && (dir_nxt == DIR_DN);
        end
    end

endmodule

// File: tb/tb_adjust_step_gen.sv
// Scoreboard bench for adjust_step_gen with DB=4, HOLD=10, RATE=3.
// Stimulus queues expected pulse cycles; a negedge monitor pops and compares.
module tb_adjust_step_gen;
    import adjust_step_pkg::*;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RATE = 3;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic btn_up;
    logic btn_down;
    logic up;
    logic Down;

    always #5 clk = ~clk;

    adjust_step_gen #(
        .DB_CYCLES   (DB),
        .HOLD_CYCLES (HOLD),
        .RATE_CYCLES (RATE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .up       (up),
        .Down     (Down)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   at;
        logic dn;
    } exp_t;

    exp_t expq[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    logic mon_on = 1'b0;

    task automatic expect_pulse(input int at, input logic dn);
        exp_t e;
        e.at = at;
        e.dn = dn;
        expq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Clean press of len clocks: first pulse at +DB+3, then +HOLD, then every RATE,
    // up to and including the clock the debounced level falls.
    task automatic press(input logic dn, input int len);
        int e;
        int t;
        e = cyc;
        t = e + DB + 3;
        if (t <= e + len + DB + 2) expect_pulse(t, dn);
        t = t + HOLD;
        while (t <= e + len + DB + 2) begin
            expect_pulse(t, dn);
            t = t + RATE;
        end
        if (dn) btn_down = 1'b1;
        else btn_up = 1'b1;
        step(len);
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (expq.size() > 0 && cyc > expq[0].at) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse got none required cycle %0d dn %0d", expq[0].at, expq[0].dn);
                void'(expq.pop_front());
            end
            if (up || Down) begin
                checks++;
                if (up && Down) begin
                    errors++;
                    $display("FAIL both_high got up=1 Down=1 required exclusive (cycle %0d)", cyc);
                end else if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse got up=%0d Down=%0d at cycle %0d required none", up, Down, cyc);
                end else begin
                    me = expq.pop_front();
                    if (me.at != cyc || me.dn != Down) begin
                        errors++;
                        $display("FAIL pulse_match got cycle %0d dn %0d required cycle %0d dn %0d",
                                 cyc, Down, me.at, me.dn);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish required finish by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int   e;
        logic bounce_seen;
        reset    = 1'b1;
        en       = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(3);
        reset = 1'b0;
        chk("reset_up", int'(up), 0);
        chk("reset_down", int'(Down), 0);
        chk("reset_state", int'(dut.state), int'(IDLE));
        step(10);
        mon_on = 1'b1;

        // single press: one up pulse at rise+7
        press(1'b0, 8);
        step(20);

        // bounce: toggling every 2 clocks never settles
        bounce_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_down = ~btn_down;
            repeat (2) begin
                step(1);
                bounce_seen = bounce_seen | dut.u_db_dn.db;
            end
        end
        btn_down = 1'b0;
        step(10);
        chk("bounce_db_dn", int'(bounce_seen), 0);

        // auto-repeat
        press(1'b0, 40);
        step(20);

        // simultaneous press locks out both directions
        e = cyc;
        expect_pulse(e + 7, 1'b1);
        expect_pulse(e + 17, 1'b1);
        expect_pulse(e + 20, 1'b1);
        expect_pulse(e + 23, 1'b1);
        btn_down = 1'b1;
        step(18);
        btn_up = 1'b1;
        step(12);
        chk("lock_state", int'(dut.state), int'(LOCK));
        btn_down = 1'b0;
        step(15);
        chk("lock_hold_state", int'(dut.state), int'(LOCK));
        btn_up = 1'b0;
        step(15);
        press(1'b0, 8);
        step(20);

        // enable gating: en drops on the clock before a due pulse
        e = cyc;
        expect_pulse(e + 7, 1'b0);
        expect_pulse(e + 17, 1'b0);
        expect_pulse(e + 20, 1'b0);
        btn_up = 1'b1;
        step(22);
        en = 1'b0;
        step(1);
        chk("en_low_up", int'(up), 0);
        chk("en_low_state", int'(dut.state), int'(IDLE));
        step(7);
        en = 1'b1;
        step(20);
        btn_up = 1'b0;
        step(15);
        press(1'b0, 8);
        step(20);

        // reset in HOLD with btn_down held
        e = cyc;
        expect_pulse(e + 7, 1'b1);
        btn_down = 1'b1;
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_mid_up", int'(up), 0);
        chk("rst_mid_down", int'(Down), 0);
        chk("rst_mid_state", int'(dut.state), int'(IDLE));
        step(29);
        btn_down = 1'b0;
        step(15);
        press(1'b1, 8);
        step(20);

        mon_on = 1'b0;
        while (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_pulse got none required cycle %0d dn %0d", expq[0].at, expq[0].dn);
            void'(expq.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
